// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and the {remainder, quotient} packing helper.
package alu_pkg;
  localparam logic [4:0] OP_OR   = 5'd0;
  localparam logic [4:0] OP_AND  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_ADDU = 5'd4;
  localparam logic [4:0] OP_MUL  = 5'd5;
  localparam logic [4:0] OP_DIV  = 5'd6;
  localparam logic [4:0] OP_DIVU = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ROR  = 5'd12;
  localparam logic [4:0] OP_NEG  = 5'd13;
  localparam logic [4:0] OP_NOT  = 5'd14;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV_RUN, S_DIV_FIX} state_e;

  // Packs remainder above quotient; w is the operand width (up to 64).
  function automatic logic [127:0] pack_rq(input logic [63:0] rem, input logic [63:0] quot, input int w);
    return (128'(rem) << w) | 128'(quot);
  endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock on magnitudes,
// with the sign fix-up applied on the outputs.
module seq_divider import alu_pkg::*; #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] q_q, r_q, d_q;
  logic [CW-1:0] cnt_q;
  logic run_q, done_q, qn_q, rn_q, sa, sb;
  logic [W:0] sh, diff;
  assign sa = signed_mode & dividend[W-1];
  assign sb = signed_mode & divisor[W-1];
  assign sh = {r_q, q_q[W-1]};
  assign diff = sh - {1'b0, d_q};
  assign div_zero = divisor == '0;
  // Remainder follows the dividend's sign, so truncation is toward zero.
  assign quotient = qn_q ? -q_q : q_q;
  assign remainder = rn_q ? -r_q : r_q;
  assign done = done_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
      qn_q <= 1'b0;
      rn_q <= 1'b0;
    end else if (start) begin
      run_q <= 1'b1;
      done_q <= 1'b0;
      cnt_q <= CW'(W);
      q_q <= sa ? -dividend : dividend;
      r_q <= '0;
      d_q <= sb ? -divisor : divisor;
      qn_q <= sa ^ sb;
      rn_q <= sa;
    end else begin
      done_q <= run_q && cnt_q == CW'(1);
      if (run_q) begin
        cnt_q <= cnt_q - CW'(1);
        run_q <= cnt_q != CW'(1);
        r_q <= diff[W] ? sh[W-1:0] : diff[W-1:0];
        q_q <= {q_q[W-2:0], ~diff[W]};
      end
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU; single-cycle ops complete in one registered
// step, DIV/DIVU run through seq_divider.
module alu_multicycle import alu_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 5,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OP_WIDTH-1:0]     op,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic                    illegal_op,
  output logic                    carry_out
);
  localparam int W = DATA_WIDTH;
  state_e state_q;
  logic [OP_WIDTH-1:0] op_q;
  logic [W-1:0] a_q, b_q, quot, rem;
  logic [2*W-1:0] result_q, res_d, prod;
  logic done_q, dz_q, ill_q, cy_q, cy_d, dz_d, ill_d;
  logic is_div, div_zero, div_go, div_done;
  logic [SHAMT_WIDTH-1:0] sh;
  logic [SHAMT_WIDTH:0] sh_inv;
  logic [W:0] sum, dif;

  function automatic logic [2*W-1:0] zx(input logic [W-1:0] v);
    return {{W{1'b0}}, v};
  endfunction

  function automatic logic [2*W-1:0] sx(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  assign is_div = op == OP_DIV || op == OP_DIVU;
  // A zero divisor skips the divider and finishes through EXEC with latency 1.
  assign div_go = state_q == S_IDLE && start && is_div && !div_zero;

  seq_divider #(.W(W)) u_div (
    .clk(clk), .reset(reset), .start(div_go), .signed_mode(op == OP_DIV),
    .dividend(A), .divisor(B), .quotient(quot), .remainder(rem),
    .div_zero(div_zero), .done(div_done)
  );

  assign sh = b_q[SHAMT_WIDTH-1:0];
  assign sh_inv = (SHAMT_WIDTH + 1)'(W) - {1'b0, sh};
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign dif = {1'b0, a_q} - {1'b0, b_q};
  assign prod = (2*W)'($signed(a_q)) * (2*W)'($signed(b_q));

  always_comb begin
    res_d = '0;
    cy_d = 1'b0;
    dz_d = 1'b0;
    ill_d = 1'b0;
    case (op_q)
      OP_OR:   res_d = zx(a_q | b_q);
      OP_AND:  res_d = zx(a_q & b_q);
      OP_ADD:  begin res_d = sx(sum[W-1:0]); cy_d = sum[W]; end
      OP_SUB:  begin res_d = sx(dif[W-1:0]); cy_d = dif[W]; end
      OP_ADDU: begin res_d = zx(sum[W-1:0]); cy_d = sum[W]; end
      OP_MUL:  res_d = prod;
      OP_DIV, OP_DIVU: begin res_d = {a_q, {W{1'b1}}}; dz_d = 1'b1; end
      OP_SHL:  res_d = zx(a_q << sh);
      OP_SHR:  res_d = zx(a_q >> sh);
      OP_SHRA: res_d = zx($signed(a_q) >>> sh);
      OP_ROL:  res_d = zx((a_q << sh) | (a_q >> sh_inv));
      OP_ROR:  res_d = zx((a_q >> sh) | (a_q << sh_inv));
      OP_NEG:  res_d = sx(-a_q);
      OP_NOT:  res_d = zx(~a_q);
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
      ill_q <= 1'b0;
      cy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q <= 1'b0;
      ill_q <= 1'b0;
      cy_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          op_q <= op;
          a_q <= A;
          b_q <= B;
          state_q <= div_go ? S_DIV_RUN : S_EXEC;
        end
        S_EXEC: begin
          result_q <= res_d;
          done_q <= 1'b1;
          dz_q <= dz_d;
          ill_q <= ill_d;
          cy_q <= cy_d;
          state_q <= S_IDLE;
        end
        S_DIV_RUN: if (div_done) state_q <= S_DIV_FIX;
        default: begin
          result_q <= (2*W)'(pack_rq(64'(rem), 64'(quot), W));
          done_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign div_by_zero = dz_q;
  assign illegal_op = ill_q;
  assign carry_out = cy_q;
endmodule
